mem_march_master: RTL
=====================

# mem_march_master

Sequencing initiator for the 16 x 8 read/write memory. On a start pulse it drives the memory's write-enable, address and write-data lines through a two-phase write/read-back test: it writes a seeded pattern to all 16 locations, reads each one back and compares it, then repeats the test with the inverted pattern. It reports pass/fail, the error count and the first failing location. The block sits between the test/control logic and the memory, on the initiator side of the memory port.

## Interface
- RD_LAT, 1: memory read latency in cycles, from address presented to mem_dout valid; legal range 0..3. Use 0 for a combinational-read memory.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a test; sampled only in IDLE.
- pattern  input  8  seed; captured on the accepted start.
- mem_w  output  1  memory write enable (1 = write, 0 = read).
- mem_addr  output  4  memory address.
- mem_din  output  8  memory write data.
- mem_dout  input  8  memory read data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  test result; valid from done until the next accepted start.
- err_count  output  6  number of mismatches, 0..32.
- fail_addr  output  4  address of the first mismatch.
- fail_data  output  8  data read at the first mismatch.
- fail_phase  output  1  phase of the first mismatch.

## Operation
- Expected data: exp(a, ph) = (seed + a) mod 256, bitwise inverted when ph = 1. The add is 8 bits wide, a is zero-extended, and the carry is dropped.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - mem_w = 0, mem_addr = 0, mem_din = 0.
  - When start = 1 at an edge: seed <= pattern, ph <= 0, a <= 0, err_count <= 0, pass <= 0, fail_* <= 0, go to WRITE.
- WRITE:
  - Each cycle: mem_w = 1, mem_addr = a, mem_din = exp(a, ph), then a <= a + 1.
  - After a = 15: a <= 0, go to READ.
- READ:
  - Each cycle: mem_w = 0, mem_addr = a, mem_din = 0, then a <= a + 1.
  - After a = 15, go to DRAIN, or to the next phase step directly if RD_LAT = 0.
- DRAIN:
  - Lasts RD_LAT cycles; mem_w = 0 and mem_addr holds 15.
  - At the end: if ph = 0, set ph <= 1, a <= 0 and go to WRITE; otherwise go to DONE.
- Compare pipeline:
  - The issued read address and ph are delayed RD_LAT cycles through a shift register.
  - When the delayed valid flag is set, mem_dout is compared to exp(delayed a, delayed ph).
  - On a mismatch, err_count increments. If it was 0, fail_addr, fail_data and fail_phase capture the delayed address, mem_dout and the delayed phase.
- DONE:
  - One cycle: done = 1, busy = 0, pass = (err_count == 0).
  - Next state is IDLE.
- start while busy, or during the DONE cycle, is ignored. No queuing.
- err_count cannot exceed 32, so no saturation logic is needed.

## Timing
- Reset values: mem_w 0, mem_addr 0, mem_din 0, busy 0, done 0, pass 0, err_count 0, fail_addr 0, fail_data 0, fail_phase 0. State resets to IDLE.
- All outputs are registered. Call the cycle after the start edge cycle 1: it is the first WRITE cycle and busy is high.
- Schedule per phase: 16 WRITE cycles + 16 READ cycles + RD_LAT DRAIN cycles.
- done is high in cycle 2 × (32 + RD_LAT) + 1, which is cycle 67 for RD_LAT = 1.
- The last read data is compared at the final DRAIN edge, and it is reflected in pass in the DONE cycle.
- Writes and reads never overlap. WRITE of phase 1 follows the phase 0 drain with no gap.
- rst asserted mid-test forces mem_w low immediately (asynchronous). All results clear, there is no done pulse, and the block restarts only on a new start.

## Test plan
- Good memory, RD_LAT = 1, pattern = 8'h00, start for one cycle:
  - Writes go to 0..15 with data 00..0F in phase 0, then FF..F0 in phase 1.
  - done is in cycle 67; pass = 1, err_count = 0.
- Wrap-around, pattern = 8'hF8: location 8 is written 8'h00 and location 15 is written 8'h07 in phase 0; the test passes.
- Stuck-at: mem_dout bit 7 forced to 0, pattern = 8'h00, RD_LAT = 1.
  - Phase 0 passes; all 16 phase 1 reads fail.
  - Result: err_count = 16, fail_addr = 0, fail_data = 8'h7F, fail_phase = 1, pass = 0.
- RD_LAT = 0 with a combinational memory: done in cycle 65, pass = 1. Also run RD_LAT = 3: done in cycle 71, pass = 1.
- Assert start again in cycle 10: it is ignored, done still lands in cycle 67 and seed is unchanged. Assert rst in cycle 20:
  - Outputs take their reset values at once, mem_w = 0, and no done pulse occurs.
  - A later start runs a full test.

Source files
------------

// File: rtl/mem_march_master.sv
// March-style write/read-back tester for a 16 x 8 memory: writes a seeded pattern,
// reads it back, repeats with the pattern inverted, and reports the result.
module mem_march_master #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pattern,
    output logic       mem_w,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [3:0] fail_addr,
    output logic [7:0] fail_data,
    output logic       fail_phase
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t     state, state_n;
    logic [3:0] a, a_n;
    logic       ph, ph_n;
    logic [7:0] seed, seed_n;
    logic [1:0] cnt, cnt_n;
    logic [5:0] err_n;
    logic [3:0] fa_n;
    logic [7:0] fd_n;
    logic       fp_n;
    logic       pass_n;
    logic       w_n;
    logic [3:0] addr_n;
    logic [7:0] din_n;
    logic       iss_v, cmp_v, cmp_ph, phase_end, mism;
    logic [3:0] cmp_a;

    function automatic logic [7:0] exp_data(input logic [7:0] s, input logic [3:0] ad,
                                            input logic p);
        logic [7:0] v;
        v = s + {4'b0000, ad};
        return p ? ~v : v;
    endfunction

    assign iss_v = (state == READ);

    // Read address/phase travel alongside the memory latency so each returning
    // word is checked against what was asked for.
    if (RD_LAT == 0) begin : g_nopipe
        assign cmp_v  = iss_v;
        assign cmp_a  = a;
        assign cmp_ph = ph;
    end else begin : g_pipe
        logic       pv [RD_LAT];
        logic [3:0] pa [RD_LAT];
        logic       pp [RD_LAT];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < RD_LAT; i++) begin
                    pv[i] <= 1'b0;
                    pa[i] <= 4'd0;
                    pp[i] <= 1'b0;
                end
            end else begin
                pv[0] <= iss_v;
                pa[0] <= a;
                pp[0] <= ph;
                for (int i = 1; i < RD_LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pa[i] <= pa[i-1];
                    pp[i] <= pp[i-1];
                end
            end
        end

        assign cmp_v  = pv[RD_LAT-1];
        assign cmp_a  = pa[RD_LAT-1];
        assign cmp_ph = pp[RD_LAT-1];
    end

    assign phase_end = ((state == READ) && (a == 4'd15) && (RD_LAT == 0)) ||
                       ((state == DRAIN) && (cnt == 2'(RD_LAT - 1)));
    assign mism = cmp_v && (mem_dout != exp_data(seed, cmp_a, cmp_ph));

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        state_n = state;
        a_n     = a;
        ph_n    = ph;
        seed_n  = seed;
        cnt_n   = cnt;
        err_n   = err_count;
        fa_n    = fail_addr;
        fd_n    = fail_data;
        fp_n    = fail_phase;
        pass_n  = pass;

        if (mism) begin
            err_n = err_count + 6'd1;
            if (err_count == 6'd0) begin
                fa_n = cmp_a;
                fd_n = mem_dout;
                fp_n = cmp_ph;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    seed_n  = pattern;
                    ph_n    = 1'b0;
                    a_n     = 4'd0;
                    err_n   = 6'd0;
                    pass_n  = 1'b0;
                    fa_n    = 4'd0;
                    fd_n    = 8'd0;
                    fp_n    = 1'b0;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                a_n = a + 4'd1;
                if (a == 4'd15) state_n = READ;
            end
            READ: begin
                a_n = a + 4'd1;
                if (a == 4'd15) begin
                    state_n = DRAIN;
                    cnt_n   = 2'd0;
                end
            end
            DRAIN:   cnt_n = cnt + 2'd1;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (phase_end) begin
            if (!ph) begin
                ph_n    = 1'b1;
                a_n     = 4'd0;
                state_n = WRITE;
            end else begin
                state_n = DONE;
            end
        end

        if (state_n == DONE) pass_n = (err_n == 6'd0);

        w_n    = (state_n == WRITE);
        addr_n = 4'd0;
        din_n  = 8'd0;
        if (state_n == WRITE) begin
            addr_n = a_n;
            din_n  = exp_data(seed_n, a_n, ph_n);
        end else if (state_n == READ) begin
            addr_n = a_n;
        end else if (state_n == DRAIN) begin
            addr_n = 4'd15;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a          <= 4'd0;
            ph         <= 1'b0;
            seed       <= 8'd0;
            cnt        <= 2'd0;
            mem_w      <= 1'b0;
            mem_addr   <= 4'd0;
            mem_din    <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 6'd0;
            fail_addr  <= 4'd0;
            fail_data  <= 8'd0;
            fail_phase <= 1'b0;
        end else begin
            state      <= state_n;
            a          <= a_n;
            ph         <= ph_n;
            seed       <= seed_n;
            cnt        <= cnt_n;
            mem_w      <= w_n;
            mem_addr   <= addr_n;
            mem_din    <= din_n;
            busy       <= (state_n == WRITE) || (state_n == READ) || (state_n == DRAIN);
            done       <= (state_n == DONE);
            pass       <= pass_n;
            err_count  <= err_n;
            fail_addr  <= fa_n;
            fail_data  <= fd_n;
            fail_phase <= fp_n;
        end
    end

endmodule
